// File: rtl/blink_monitor.sv
// blink_monitor: checks a 4-lane LED blink stream for half-period accuracy and lane agreement, then reports lock or fault.
// Latency: led_in is registered once, and status outputs are registered one cycle after the sampled edge.
// Backpressure: none. The monitor only observes. Defining BLINK_MON_STICKY_EN makes FAULT exit only through rst_n.
module blink_monitor #(
    parameter logic [27:0] HALF_PERIOD = 28'd134217728,
    parameter logic [27:0] TOL         = 28'd16,
    parameter int unsigned LOCK_COUNT  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  led_in,
    input  logic        clr,
    output logic        locked,
    output logic        fault,
    output logic [1:0]  err_code,
    output logic [27:0] last_len,
    output logic [15:0] edge_cnt
);

    localparam int GW = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);

    localparam logic [27:0] HP_MAX = 28'hFFFFFFF;
    // Bounds are one bit wider so that HALF_PERIOD+TOL cannot wrap.
    localparam logic [28:0] LEN_LO = (HALF_PERIOD > TOL) ? {1'b0, HALF_PERIOD - TOL} : 29'd0;
    localparam logic [28:0] LEN_HI = {1'b0, HALF_PERIOD} + {1'b0, TOL};

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_SHORT = 2'b01;
    localparam logic [1:0] ERR_LONG  = 2'b10;
    localparam logic [1:0] ERR_LANE  = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2,
        FAULT   = 2'd3
    } state_t;

    state_t          state;
    logic [3:0]      led_s;
    logic            led_prev;
    logic [27:0]     hp_cnt;
    logic [GW-1:0]   good_cnt;

    logic            edge_det;
    logic            lane_err;
    logic [28:0]     meas_len;
    logic            too_short;
    logic            too_long;
    logic            lock_hit;

    always_comb begin
        edge_det  = led_s[0] ^ led_prev;
        lane_err  = (led_s != 4'h0) && (led_s != 4'hF);
        meas_len  = {1'b0, hp_cnt} + 29'd1;
        too_short = edge_det && (meas_len < LEN_LO);
        // The same test covers a late edge and a missing edge.
        too_long  = meas_len > LEN_HI;
        lock_hit  = (32'(good_cnt) + 32'd1) >= LOCK_COUNT;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            locked   <= 1'b0;
            fault    <= 1'b0;
            err_code <= ERR_NONE;
            last_len <= '0;
            edge_cnt <= '0;
            hp_cnt   <= '0;
            good_cnt <= '0;
            led_s    <= '0;
            led_prev <= 1'b0;
        end else begin
            led_s    <= led_in;
            led_prev <= led_s[0];

            if (edge_det) begin
                hp_cnt   <= '0;
                last_len <= meas_len[28] ? HP_MAX : meas_len[27:0];
                edge_cnt <= edge_cnt + 16'd1;
            end else if (hp_cnt != HP_MAX) begin
                hp_cnt <= hp_cnt + 28'd1;
            end

            case (state)
                IDLE: begin
                    if (lane_err) begin
                        state    <= FAULT;
                        fault    <= 1'b1;
                        err_code <= ERR_LANE;
                    end else if (edge_det) begin
                        state    <= MEASURE;
                        good_cnt <= '0;
                    end
                end
                MEASURE, LOCKED: begin
                    if (lane_err) begin
                        state    <= FAULT;
                        locked   <= 1'b0;
                        fault    <= 1'b1;
                        err_code <= ERR_LANE;
                    end else if (too_short) begin
                        state    <= FAULT;
                        locked   <= 1'b0;
                        fault    <= 1'b1;
                        err_code <= ERR_SHORT;
                    end else if (too_long) begin
                        state    <= FAULT;
                        locked   <= 1'b0;
                        fault    <= 1'b1;
                        err_code <= ERR_LONG;
                    end else if (edge_det && state == MEASURE) begin
                        good_cnt <= good_cnt + GW'(1);
                        if (lock_hit) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end
                    end
                end
                FAULT: begin
`ifdef BLINK_MON_STICKY_EN
                    // Only rst_n can leave FAULT, so clr has no effect here.
`else
                    if (clr) begin
                        state    <= IDLE;
                        fault    <= 1'b0;
                        err_code <= ERR_NONE;
                        good_cnt <= '0;
                    end
`endif
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_blink_monitor.sv
// tb_blink_monitor: directed and random LED stimulus checked every cycle against a timestamp-based reference model.
// Latency: outputs are sampled 1ns after each rising edge.
// Backpressure: not applicable.
`timescale 1ns/1ps
module tb_blink_monitor;

    localparam logic [27:0] HP   = 28'd8;
    localparam logic [27:0] TOLV = 28'd1;
    localparam int          LC   = 2;
    localparam int          LO   = 7;
    localparam int          HI   = 9;
`ifdef BLINK_MON_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        clr    = 1'b0;
    logic [3:0]  led_in = 4'h0;
    logic        locked;
    logic        fault;
    logic [1:0]  err_code;
    logic [27:0] last_len;
    logic [15:0] edge_cnt;

    blink_monitor #(
        .HALF_PERIOD (HP),
        .TOL         (TOLV),
        .LOCK_COUNT  (LC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .led_in   (led_in),
        .clr      (clr),
        .locked   (locked),
        .fault    (fault),
        .err_code (err_code),
        .last_len (last_len),
        .edge_cnt (edge_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    // Reference model: edges are timestamps, and a fault is a nonzero code.
    int         cyc           = 0;
    int         last_edge_cyc = 0;
    logic [3:0] seen_led      = 4'h0;
    logic       seen_prev     = 1'b0;
    bit         armed         = 1'b0;
    int         good          = 0;
    int         m_err         = 0;
    int         m_last_len    = 0;
    logic [15:0] m_edges      = 16'h0;

    task automatic model_step(input logic [3:0] led, input logic c, input logic r);
        bit edge_seen;
        bit lane_bad;
        int len;
        cyc++;
        if (!r) begin
            armed = 1'b0; good = 0; m_err = 0; m_last_len = 0; m_edges = 16'h0;
            last_edge_cyc = cyc; seen_led = 4'h0; seen_prev = 1'b0;
            return;
        end
        edge_seen = (seen_led[0] != seen_prev);
        lane_bad  = !(seen_led == 4'h0 || seen_led == 4'hF);
        len       = cyc - last_edge_cyc;
        if (edge_seen) begin
            m_edges++;
            m_last_len    = len;
            last_edge_cyc = cyc;
        end
        if (m_err != 0) begin
            if (c && !STICKY) begin
                m_err = 0; armed = 1'b0; good = 0;
            end
        end else if (lane_bad) m_err = 3;
        else if (!armed) begin
            if (edge_seen) begin
                armed = 1'b1; good = 0;
            end
        end else if (edge_seen && len < LO) m_err = 1;
        else if (len > HI) m_err = 2;
        else if (edge_seen && good < LC) good++;
        seen_prev = seen_led[0];
        seen_led  = led;
    endtask

    task automatic step(input logic [3:0] led, input logic c, input logic r);
        led_in = led; clr = c; rst_n = r;
        @(posedge clk);
        model_step(led, c, r);
        #1;
        chk_eq("locked",   32'(locked),   32'(m_err == 0 && armed && good >= LC));
        chk_eq("fault",    32'(fault),    32'(m_err != 0));
        chk_eq("err_code", 32'(err_code), 32'(m_err));
        chk_eq("last_len", 32'(last_len), 32'(m_last_len));
        chk_eq("edge_cnt", 32'(edge_cnt), 32'(m_edges));
    endtask

    logic [3:0] cur = 4'h0;

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) step(cur, 1'b0, 1'b1);
    endtask

    task automatic toggle(input int period);
        cur = ~cur;
        step(cur, 1'b0, 1'b1);
        hold(period - 1);
    endtask

    task automatic do_reset();
        cur = 4'h0;
        step(4'h0, 1'b0, 1'b0);
        step(4'h0, 1'b0, 1'b0);
    endtask

    int r;

    initial begin
        // Lock on three 8-cycle toggles.
        do_reset();
        hold(3);
        toggle(8); toggle(8); toggle(8);
        chk_eq("lock_locked",   32'(locked),   32'd1);
        chk_eq("lock_last_len", 32'(last_len), 32'd8);
        chk_eq("lock_fault",    32'(fault),    32'd0);

        // A 5-cycle interval while locked is short.
        toggle(5); toggle(3);
        chk_eq("short_fault",   32'(fault),    32'd1);
        chk_eq("short_err",     32'(err_code), 32'd1);
        chk_eq("short_len",     32'(last_len), 32'd5);
        chk_eq("short_locked",  32'(locked),   32'd0);

        // Pulse clr while in FAULT.
        step(cur, 1'b1, 1'b1);
        step(cur, 1'b0, 1'b1);
        chk_eq("clr_fault", 32'(fault),    32'(STICKY));
        chk_eq("clr_err",   32'(err_code), STICKY ? 32'd1 : 32'd0);

        // Static LEDs after lock time out on the 10th cycle after the last edge.
        do_reset();
        hold(2);
        toggle(8); toggle(8); toggle(8);
        hold(3);
        chk_eq("timeout_pre", 32'(fault), 32'd0);
        hold(1);
        chk_eq("timeout_fault", 32'(fault),    32'd1);
        chk_eq("timeout_err",   32'(err_code), 32'd2);

        // A one-cycle lane mismatch during MEASURE.
        do_reset();
        hold(2);
        toggle(8);
        step(4'b0111, 1'b0, 1'b1);
        step(cur, 1'b0, 1'b1);
        chk_eq("lane_fault", 32'(fault),    32'd1);
        chk_eq("lane_err",   32'(err_code), 32'd3);

        // Reset while locked, then relock after three toggles.
        do_reset();
        hold(2);
        toggle(8); toggle(8); toggle(8);
        chk_eq("rst_pre_locked", 32'(locked), 32'd1);
        cur = 4'h0;
        step(cur, 1'b0, 1'b0);
        chk_eq("rst_locked",   32'(locked),   32'd0);
        chk_eq("rst_fault",    32'(fault),    32'd0);
        chk_eq("rst_err",      32'(err_code), 32'd0);
        chk_eq("rst_last_len", 32'(last_len), 32'd0);
        chk_eq("rst_edge_cnt", 32'(edge_cnt), 32'd0);
        hold(3);
        toggle(8); toggle(8);
        chk_eq("relock_two", 32'(locked), 32'd0);
        toggle(8);
        chk_eq("relock_three", 32'(locked), 32'd1);

        // Random phase: mixed intervals, glitches, clr pulses and resets.
        for (int it = 0; it < 400; it++) begin
            r = $urandom_range(0, 99);
            if (r < 60) toggle($urandom_range(6, 10));
            else if (r < 70) toggle($urandom_range(1, 14));
            else if (r < 78) begin
                step(4'($urandom_range(0, 15)), 1'b0, 1'b1);
                hold(1);
            end else if (r < 88) begin
                step(cur, 1'b1, 1'b1);
                hold(1);
            end else if (r < 93) begin
                step(cur, 1'b0, 1'b0);
                hold(1);
            end else hold($urandom_range(1, 12));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
